// File: rtl/mem_port_arbiter_if.sv
//==============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Requester A/B handshake and memory pin bundle for mem_port_arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic              a_done;
    logic              a_err;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] b_rdata;
    logic              b_done;
    logic              b_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write;
    logic              mem_memread;
    logic              mem_memwrite;
    logic [DATA_W-1:0] mem_read;

    logic              busy;
    logic              grant_b;

    // Requesters and the memory sit on the master side.
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_rdata, a_done, a_err,
        output b_req, b_we, b_addr, b_wdata,
        input  b_rdata, b_done, b_err,
        input  mem_addr, mem_write, mem_memread, mem_memwrite,
        output mem_read,
        input  busy, grant_b
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_rdata, a_done, a_err,
        input  b_req, b_we, b_addr, b_wdata,
        output b_rdata, b_done, b_err,
        output mem_addr, mem_write, mem_memread, mem_memwrite,
        input  mem_read,
        output busy, grant_b
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin two-port arbiter/sequencer for a single-port data memory.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int          ADDR_W   = 16,
    parameter int          DATA_W   = 16,
    parameter int unsigned MAX_ADDR = 32
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_max_addr = ADDR_W'(MAX_ADDR);

    state_t            r_state;
    state_t            w_state_nxt;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_take;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_we;
    logic              w_sel_oor;

    logic              r_last_b;
    logic              r_owner_b;
    logic              r_we;
    logic              r_oor;
    logic [DATA_W-1:0] r_cap;

    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_write;
    logic              r_mem_memread;
    logic              r_mem_memwrite;
    logic [DATA_W-1:0] r_a_rdata;
    logic              r_a_done;
    logic              r_a_err;
    logic [DATA_W-1:0] r_b_rdata;
    logic              r_b_done;
    logic              r_b_err;
    logic              r_busy;

    // On a tie the port that was not granted last wins.
    always_comb begin
        w_grant_a   = 1'b0;
        w_grant_b   = 1'b0;
        w_state_nxt = r_state;
        if (r_state == S_IDLE) begin
            w_grant_a = bus.a_req && (!bus.b_req ||  r_last_b);
            w_grant_b = bus.b_req && (!bus.a_req || !r_last_b);
        end
        w_take      = w_grant_a || w_grant_b;
        w_sel_addr  = w_grant_b ? bus.b_addr  : bus.a_addr;
        w_sel_wdata = w_grant_b ? bus.b_wdata : bus.a_wdata;
        w_sel_we    = w_grant_b ? bus.b_we    : bus.a_we;
        w_sel_oor   = (w_sel_addr > c_max_addr);

        case (r_state)
            S_IDLE:  w_state_nxt = w_take ? S_ISSUE : S_IDLE;
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_b       <= 1'b1;
            r_owner_b      <= 1'b0;
            r_we           <= 1'b0;
            r_oor          <= 1'b0;
            r_cap          <= '0;
            r_mem_addr     <= '0;
            r_mem_write    <= '0;
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_a_rdata      <= '0;
            r_a_done       <= 1'b0;
            r_a_err        <= 1'b0;
            r_b_rdata      <= '0;
            r_b_done       <= 1'b0;
            r_b_err        <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_a_done       <= 1'b0;
            r_a_err        <= 1'b0;
            r_b_done       <= 1'b0;
            r_b_err        <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_busy         <= (w_state_nxt != S_IDLE);

            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_last_b       <= w_grant_b;
                        r_owner_b      <= w_grant_b;
                        r_we           <= w_sel_we;
                        r_oor          <= w_sel_oor;
                        r_mem_addr     <= w_sel_addr;
                        r_mem_write    <= w_sel_wdata;
                        // Strobes are valid only during ISSUE; out-of-range never touches memory.
                        r_mem_memread  <= !w_sel_we && !w_sel_oor;
                        r_mem_memwrite <=  w_sel_we && !w_sel_oor;
                    end
                end
                S_RESP: begin
                    r_cap <= bus.mem_read;
                end
                S_DONE: begin
                    if (r_owner_b) begin
                        r_b_done <= 1'b1;
                        r_b_err  <= r_oor;
                        if (!r_we && !r_oor) begin
                            r_b_rdata <= r_cap;
                        end
                    end else begin
                        r_a_done <= 1'b1;
                        r_a_err  <= r_oor;
                        if (!r_we && !r_oor) begin
                            r_a_rdata <= r_cap;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_write    = r_mem_write;
    assign bus.mem_memread  = r_mem_memread;
    assign bus.mem_memwrite = r_mem_memwrite;
    assign bus.a_rdata      = r_a_rdata;
    assign bus.a_done       = r_a_done;
    assign bus.a_err        = r_a_err;
    assign bus.b_rdata      = r_b_rdata;
    assign bus.b_done       = r_b_done;
    assign bus.b_err        = r_b_err;
    assign bus.busy         = r_busy;
    // grant_b reads 0 after reset even though B is internally "last" so A wins the first tie.
    assign bus.grant_b      = r_owner_b;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter with a transaction-level model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int          ADDR_W   = 16;
    localparam int          DATA_W   = 16;
    localparam int unsigned MAX_ADDR = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_ADDR(MAX_ADDR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    // Registered-read single-port RAM.
    logic [15:0] ram [0:63] = '{default: 16'h0000};
    always @(posedge clock) begin
        if (bus.mem_memwrite) ram[bus.mem_addr[5:0]] <= bus.mem_write;
        if (bus.mem_memread)  bus.mem_read <= ram[bus.mem_addr[5:0]];
    end

    // Transaction-level reference: grant at edge k, completion pulse after edge k+3.
    logic [15:0] ref_mem [0:63] = '{default: 16'h0000};
    int unsigned ecount   = 0;
    int unsigned m_start  = 0;
    bit          m_active = 1'b0;
    bit          m_own_b  = 1'b0;
    bit          m_last_b = 1'b1;
    bit          m_we     = 1'b0;
    bit          m_inr    = 1'b0;
    logic [15:0] m_addr   = '0;
    logic [15:0] m_wdata  = '0;
    logic [15:0] e_mem_addr = '0, e_mem_write = '0, e_a_rdata = '0, e_b_rdata = '0;
    bit e_memread = 0, e_memwrite = 0, e_busy = 0, e_grant_b = 0;
    bit e_a_done = 0, e_a_err = 0, e_b_done = 0, e_b_err = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active = 0; m_last_b = 1; m_own_b = 0;
            e_mem_addr = '0; e_mem_write = '0; e_a_rdata = '0; e_b_rdata = '0;
            e_memread = 0; e_memwrite = 0; e_busy = 0; e_grant_b = 0;
            e_a_done = 0; e_a_err = 0; e_b_done = 0; e_b_err = 0;
        end else begin
            ecount++;
            e_a_done = 0; e_a_err = 0; e_b_done = 0; e_b_err = 0;
            if (m_active && ecount == m_start + 3) begin
                if (m_own_b) begin
                    e_b_done = 1; e_b_err = !m_inr;
                    if (m_inr && !m_we) e_b_rdata = ref_mem[m_addr[5:0]];
                end else begin
                    e_a_done = 1; e_a_err = !m_inr;
                    if (m_inr && !m_we) e_a_rdata = ref_mem[m_addr[5:0]];
                end
                if (m_inr && m_we) ref_mem[m_addr[5:0]] = m_wdata;
                m_active = 0;
            end else if (!m_active && (bus.a_req || bus.b_req)) begin
                if (bus.a_req && bus.b_req) m_own_b = !m_last_b;
                else                        m_own_b = bus.b_req;
                m_addr  = m_own_b ? bus.b_addr  : bus.a_addr;
                m_wdata = m_own_b ? bus.b_wdata : bus.a_wdata;
                m_we    = m_own_b ? bus.b_we    : bus.a_we;
                m_inr   = (int'(m_addr) <= int'(MAX_ADDR));
                m_start = ecount; m_active = 1; m_last_b = m_own_b;
                e_grant_b = m_own_b; e_mem_addr = m_addr; e_mem_write = m_wdata;
            end
            e_busy     = m_active;
            e_memread  = m_active && (ecount == m_start) && !m_we && m_inr;
            e_memwrite = m_active && (ecount == m_start) &&  m_we && m_inr;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int strobe_cnt = 0;
    bit sim_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ctrl_vec();
        return {bus.a_done, bus.a_err, bus.b_done, bus.b_err,
                bus.mem_memread, bus.mem_memwrite, bus.busy, bus.grant_b};
    endfunction

    function automatic logic [63:0] data_vec();
        return {bus.a_rdata, bus.b_rdata, bus.mem_addr, bus.mem_write};
    endfunction

    task automatic set_port(input bit pb, input bit req, input bit we,
                            input logic [15:0] addr, input logic [15:0] wd);
        if (pb) begin
            bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
        end else begin
            bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
        end
    endtask

    task automatic txn(input bit pb, input bit we, input logic [15:0] addr,
                       input logic [15:0] wd, input bit keep, output int lat);
        bit ok = 0;
        lat = 0;
        set_port(pb, 1'b1, we, addr, wd);
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clock);
            lat++;
            if (pb ? bus.b_done : bus.a_done) ok = 1;
        end
        check("txn_done_timeout", ok, 1);
        if (!keep) set_port(pb, 1'b0, we, addr, wd);
    endtask

    task automatic reset_dut();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drive(input bit pb, input int n);
        int lat;
        bit hold = 0;
        for (int t = 0; t < n; t++) begin
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clock);
            hold = ($urandom_range(0, 2) == 0);
            txn(pb, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 40)), 16'($urandom), hold, lat);
            check("rand_latency_bound", (lat >= 4 && lat <= 8), 1);
        end
        set_port(pb, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        fork
            begin : compare
                while (!sim_done) begin
                    @(negedge clock);
                    check("cycle_data", data_vec(),
                          {e_a_rdata, e_b_rdata, e_mem_addr, e_mem_write});
                    check("cycle_ctrl", 64'(ctrl_vec()),
                          64'({e_a_done, e_a_err, e_b_done, e_b_err,
                               e_memread, e_memwrite, e_busy, e_grant_b}));
                    check("rd_wr_exclusive", bus.mem_memread & bus.mem_memwrite, 0);
                    if (bus.mem_memread || bus.mem_memwrite) strobe_cnt++;
                end
            end
            begin : stimulus
                int lat;
                int seq[$];
                int tms[$];
                int s0;
                set_port(0, 0, 0, 16'h0, 16'h0);
                set_port(1, 0, 0, 16'h0, 16'h0);
                repeat (2) @(negedge clock);
                check("reset_ctrl", 64'(ctrl_vec()), 0);
                check("reset_data", data_vec(), 0);
                reset = 1'b0;

                // Write then read back on A.
                txn(0, 1, 16'd5, 16'hBEEF, 0, lat);
                check("t1_wr_latency", lat, 4);
                txn(0, 0, 16'd5, 16'h0000, 0, lat);
                check("t1_rd_latency", lat, 4);
                check("t1_rdata", bus.a_rdata, 16'hBEEF);
                check("t1_err", bus.a_err, 0);
                check("t1_model_rdata", e_a_rdata, 16'hBEEF);

                // Simultaneous requests, both held: A,B,A,B.
                reset_dut();
                set_port(0, 1, 0, 16'd10, 16'h0);
                set_port(1, 1, 0, 16'd11, 16'h0);
                for (int i = 0; i < 40 && seq.size() < 4; i++) begin
                    @(negedge clock);
                    if (bus.a_done) begin seq.push_back(0); tms.push_back(i); end
                    if (bus.b_done) begin seq.push_back(1); tms.push_back(i); end
                end
                set_port(0, 0, 0, 16'h0, 16'h0);
                set_port(1, 0, 0, 16'h0, 16'h0);
                check("t2_done_count", seq.size(), 4);
                for (int k = 0; k < 4; k++)
                    check("t2_grant_order", (seq.size() > k) ? seq[k] : 9, k % 2);
                check("t2_b_after_a", (tms.size() > 1) ? tms[1] - tms[0] : 0, 4);
                @(negedge clock);

                // Range boundary on B.
                txn(1, 1, 16'd7, 16'h1234, 0, lat);
                txn(1, 0, 16'd7, 16'h0000, 0, lat);
                check("t3_rd7", bus.b_rdata, 16'h1234);
                s0 = strobe_cnt;
                txn(1, 0, 16'd33, 16'h0000, 0, lat);
                check("t3_oor_err", bus.b_err, 1);
                check("t3_oor_latency", lat, 4);
                check("t3_oor_rdata_kept", bus.b_rdata, 16'h1234);
                txn(1, 1, 16'hFFFF, 16'hDEAD, 0, lat);
                check("t3_oor_wr_err", bus.b_err, 1);
                check("t3_no_strobes", strobe_cnt - s0, 0);
                txn(1, 1, 16'd32, 16'h0F0F, 0, lat);
                txn(1, 0, 16'd32, 16'h0000, 0, lat);
                check("t3_max_err", bus.b_err, 0);
                check("t3_max_rdata", bus.b_rdata, 16'h0F0F);

                // Back-to-back with req held across done.
                txn(0, 1, 16'd20, 16'hA5C3, 1, lat);
                txn(0, 0, 16'd20, 16'h0000, 0, lat);
                check("t4_b2b_latency", lat, 4);
                check("t4_b2b_rdata", bus.a_rdata, 16'hA5C3);

                // Asynchronous reset while a read is in ISSUE.
                @(negedge clock);
                set_port(0, 1, 0, 16'd5, 16'h0);
                @(posedge clock);
                #1;
                check("t5_in_issue", bus.mem_memread, 1);
                reset = 1'b1;
                #1;
                check("t5_async_ctrl", 64'(ctrl_vec()), 0);
                check("t5_async_data", data_vec(), 0);
                set_port(0, 0, 0, 16'h0, 16'h0);
                repeat (3) @(negedge clock);
                reset = 1'b0;
                txn(0, 0, 16'd5, 16'h0000, 0, lat);
                check("t5_recover_latency", lat, 4);
                check("t5_recover_rdata", bus.a_rdata, 16'hBEEF);

                // Randomized contention on both ports.
                fork
                    drive(0, 40);
                    drive(1, 40);
                join
                repeat (6) @(negedge clock);
                sim_done = 1'b1;
            end
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
